bin2gray_stream: RTL
====================

Name: bin2gray_stream

Overview:
Sequential binary-to-Gray encoder, the transmit-side counterpart of the existing Gray-to-binary converter. It accepts binary words over a valid/ready handshake and emits registered Gray words through a 2-entry output buffer. A count mode generates successive Gray codes without input, as a stimulus source for the decoder.

Parameters:
WIDTH, 4, bit width of binary input and Gray output (minimum 2).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
cnt_mode  in  1  0 = convert input stream, 1 = free-running Gray counter.
in_valid  in  1  in_bin is valid.
in_ready  out  1  block can accept in_bin this cycle.
in_bin  in  WIDTH  binary word to encode.
out_valid  out  1  out_gray is valid.
out_ready  in  1  downstream accepts out_gray this cycle.
out_gray  out  WIDTH  Gray word at head of buffer.
wrap  out  1  one-cycle pulse when the counter rolls over from all-ones to zero.
step_ok  out  1  one-cycle pulse after each output pop from the second pop on; high if the popped word differs from the previous popped word in exactly one bit.
busy  out  1  high when the buffer is non-empty or the mode state is DRAIN.

Behaviour:
- Encoding: gray = bin ^ (bin >> 1), WIDTH bits, no truncation.
- Reset (async assert, sync release): FSM = CONV, buffer empty, counter = 0, last_gray = 0, first_pop flag set.
  - All outputs are 0 while rst is high, including in_ready, out_gray, wrap, step_ok and busy.
- Buffer: 2-entry FIFO of WIDTH-bit words.
  - out_valid = (occupancy != 0); out_gray = head entry, or 0 when empty.
  - Pop when out_valid && out_ready.
- FSM states: CONV, DRAIN, CNT.
  - CONV: in_ready = (occupancy < 2).
    - Push gray(in_bin) when in_valid && in_ready.
    - Latency: a word accepted in cycle N gives out_valid in cycle N+1 if the buffer was empty.
  - CNT: in_ready = 0.
    - Each cycle occupancy < 2: push gray(counter), then counter increments.
    - Counter wraps from 2^WIDTH-1 to 0; wrap pulses in the cycle after the all-ones word is pushed.
  - Mode change: when cnt_mode differs from the current mode, go to DRAIN.
    - DRAIN: in_ready = 0, no pushes, pops continue.
    - When occupancy = 0, enter the target mode. Entering CNT clears the counter to 0.
    - cnt_mode toggling back during DRAIN: still drain, then enter the mode cnt_mode selects at exit.
- Simultaneous push and pop:
  - Occupancy is unchanged and ordering is preserved.
  - With the buffer empty, the pushed word appears the next cycle; no same-cycle bypass.
- Full buffer with in_valid high: in_ready = 0, input is held by the upstream, no drop.
- Back-to-back throughput: one word per cycle while out_ready is held high.
- Stalled output: out_gray and out_valid hold stable until popped.
- step_ok: on pop, compare the popped word with last_gray.
  - Pulse in the next cycle if popcount(xor) == 1, then update last_gray.
  - First pop after reset only loads last_gray.
- Reset mid-operation: buffer contents are discarded immediately, out_valid drops asynchronously, and the FSM returns to CONV.

Decomposition:
- Shared package/header bin2gray_defs holds:
  - FSM state encodings ST_CONV = 2'd0, ST_DRAIN = 2'd1, ST_CNT = 2'd2.
  - The bin2gray encoding function.
  - A popcount-equals-one function.
- One sub-module: gray_fifo2, a parameterised 2-entry FIFO with push, pop, occupancy, head data and asynchronous reset.

Test Plan:
- WIDTH=4, CONV, out_ready=1; push 4'b1011, 4'b0111, 4'b1111 on consecutive cycles -> out_gray 4'b1110, 4'b0100, 4'b1000 on the next three cycles, out_valid held high throughout.
- out_ready=0; push 3 words with in_valid held -> in_ready drops after 2 accepts and the 3rd word is held. Raise out_ready -> all 3 emerge in order with no loss or duplication.
- Set cnt_mode=1 with 2 words buffered -> busy high, in_ready=0 until drained. Then the CNT sequence is 0000, 0001, 0011, 0010, 0110, ..., 1000 (bin 15), then 0000 with wrap pulsing once. step_ok pulses high on every pop after the first.
- CONV, push 4'b0000 then 4'b0011 (gray 0000, 0010), then 4'b0101 (gray 0111) -> step_ok high for the first comparison, low for the second.
- Assert rst mid-stream with 2 words buffered, asynchronously between edges -> out_valid, in_ready and out_gray go to 0 immediately. After release, FSM is CONV, in_ready=1, and the first pop produces no step_ok.

Source files
------------

// File: rtl/bin2gray_defs.sv
// Shared definitions for the binary-to-Gray stream encoder: mode encodings
// and the width-generic helpers (callers zero-extend to MAX_W and truncate).
package bin2gray_defs;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    ST_CONV  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CNT   = 2'd2
  } state_e;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // True when exactly one bit of x is set.
  function automatic logic is_one_hot(input logic [MAX_W-1:0] x);
    return (x != '0) && ((x & (x - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_fifo2.sv
// Two-entry FIFO with occupancy count; head reads as zero while empty.
module gray_fifo2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  // NOTE: payload storage is deliberately not reset; head is masked while empty,
  // so stale entries are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/bin2gray_stream.sv
// Binary-to-Gray stream encoder with a 2-deep output buffer and a
// free-running Gray counter mode; reports single-bit steps between pops.
module bin2gray_stream
  import bin2gray_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             wrap,
  output logic             step_ok,
  output logic             busy
);

  state_e           state;
  state_e           state_nxt;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] last_gray;
  logic             first_pop;
  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_word;
  logic             counter_clr;

  gray_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_word),
    .count     (occ),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CONV;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    push        = 1'b0;
    push_word   = '0;
    counter_clr = 1'b0;
    case (state)
      ST_CONV: begin
        accept    = (occ != 2'd2);
        push      = in_valid && accept;
        push_word = WIDTH'(bin2gray(MAX_W'(in_bin)));
        if (cnt_mode) state_nxt = ST_DRAIN;
      end
      ST_CNT: begin
        push      = (occ != 2'd2);
        push_word = WIDTH'(bin2gray(MAX_W'(counter)));
        if (!cnt_mode) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Target is whatever cnt_mode says at exit, not at entry.
        if (occ == 2'd0) begin
          state_nxt   = cnt_mode ? ST_CNT : ST_CONV;
          counter_clr = cnt_mode;
        end
      end
      default: state_nxt = ST_CONV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= (state == ST_CNT) && push && (&counter);
      if (counter_clr)                    counter <= '0;
      else if ((state == ST_CNT) && push) counter <= counter + WIDTH'(1);
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_gray  = head;
  assign pop       = out_valid && out_ready;
  assign busy      = out_valid || (state == ST_DRAIN);
  // Combinational ready must read low while reset is held.
  assign in_ready  = accept && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_ok   <= 1'b0;
      last_gray <= '0;
      first_pop <= 1'b1;
    end else begin
      step_ok <= 1'b0;
      if (pop) begin
        step_ok   <= !first_pop && is_one_hot(MAX_W'(head ^ last_gray));
        last_gray <= head;
        first_pop <= 1'b0;
      end
    end
  end

endmodule
